spi_slave_regfile: RTL and testbench
====================================

// Module: spi_slave_regfile
// PURPOSE
// - SPI mode-0 slave register bank on the PL side of the PS SPI master (SCLK/CS0n/MOSI from top_bd_wrapper).
// - Oversamples the bus in the clk200 domain and decodes a command byte {rw, addr[6:0]}.
// - Then writes or reads one 8-bit register per data byte; drives MISO back to the top-level MISO mux.
// - Register contents are exported to PL logic in place of the debug-register-driven test data.
// PARAMETERS
// - NUM_REGS  8      number of 8-bit registers, 1..128
// - ID_BYTE   8'hA5  byte shifted out on MISO during the command byte
// - REG_RST   8'h00  reset value of every register
// PORTS
// - clk200       in   1            sampling clock, 200 MHz
// - rst          in   1            synchronous, active-high reset
// - sclk_i       in   1            SPI clock, async to clk200, CPOL=0, max clk200/8
// - csn_i        in   1            SPI chip select, active low, async
// - mosi_i       in   1            SPI data in, MSB first, async
// - miso_o       out  1            SPI data out, registered
// - regs_o       out  NUM_REGS*8   register contents; reg n at [8n+7:8n]
// - wr_stb_o     out  1            1-cycle pulse when a register is written
// - wr_addr_o    out  7            address of the write flagged by wr_stb_o
// - busy_o       out  1            frame in progress (synced csn low)
// BEHAVIOUR
// - Reset values: regs = REG_RST, miso_o = 0, wr_stb_o = 0, wr_addr_o = 0, busy_o = 0, FSM = IDLE.
// - Input sync: sclk_i, csn_i and mosi_i each pass through 2 sync flops plus 1 history flop.
// - Edges: rise = sync & ~hist, fall = ~sync & hist; bus-event latency is 2-3 clk200 cycles.
// - Bit handling: MOSI is sampled on detected SCLK rise. MISO updates on detected SCLK fall.
// - First MISO bit: the MSB of a byte is driven on the csn fall, or on the SCLK fall that ends the previous byte.
// - FSM states: IDLE, CMD, DATA, IGNORE.
//   - IDLE -> CMD on csn fall: bit counter = 0, MISO shift reg loaded with ID_BYTE, miso_o = ID_BYTE[7].
//   - CMD: after 8 rises, latch rw and addr; go to DATA.
//   - CMD read setup: if rw=1, load the read byte on the next cycle.
//   - Read byte = regs[addr], or 8'h00 if addr >= NUM_REGS; its MSB goes to miso_o on the following SCLK fall.
//   - DATA: after 8 rises, a write frame (rw=0, addr < NUM_REGS) updates regs[addr] on the next cycle.
//   - DATA write outputs: wr_stb_o pulses 1 cycle and wr_addr_o = addr.
//   - DATA exit: go to IGNORE (see CONFIGURATION for the auto-increment alternative).
//   - IGNORE: MOSI is discarded, miso_o = 0, no writes.
//   - Any state -> IDLE on csn rise; busy_o follows synced csn (inverted).
// - Boundary conditions:
//   - miso_o = 0 whenever in IDLE.
//   - Writes to addr >= NUM_REGS are ignored: no strobe, no state change.
//   - csn rise mid-byte aborts the frame: the partial byte is discarded, no write, nothing left in the FSM.
//   - csn rise in the same cycle as the 8th rise: the rise is processed first, so a completed write byte commits.
//   - SCLK edges while in IDLE are ignored.
//   - If rst is released while csn is low, the block stays in IDLE until synced csn has been high for at least 1 cycle.
//   - regs_o is stable except in the single commit cycle.
// CONFIGURATION
// - Macro SPI_REGFILE_AUTOINC_EN.
//   - Defined: after each data byte, DATA stays in DATA and addr increments by 1, wrapping 127 -> 0.
//   - Defined, bursts: each further byte writes, or reads via MISO, the next register, so bursts are unbounded.
//   - Defined, reads: the next read byte is loaded in the cycle after the 8th rise.
//   - Not defined: exactly one data byte per frame; extra bytes land in IGNORE.
// TESTING
// - Reset, then frame 0x03,0x5A with NUM_REGS=8 -> regs[3]=0x5A.
// - Same frame, strobe check -> wr_stb_o pulses once with wr_addr_o=3; MISO in byte 0 = 0xA5.
// - Frame 0x83,0x00 after the write -> MISO byte 1 = 0x5A; no wr_stb_o; regs unchanged.
// - Frame 0x0A,0xFF (addr 10 >= 8) -> no strobe, regs unchanged.
// - Frame 0x8A,0x00 -> MISO byte 1 = 0x00.
// - csn raised after 4 bits of byte 1 of frame 0x02,0xC3 -> regs[2] unchanged, no strobe, busy_o=0.
// - Next frame after the abort decodes correctly.
// - AUTOINC_EN: frame 0x06,0x11,0x22,0x33 -> regs[6]=0x11, regs[7]=0x22, 0x33 dropped (addr 8 >= 8).
// - AUTOINC_EN: then frame 0x86,0,0 -> MISO 0x11,0x22.
// - Without AUTOINC_EN, same write frame -> only regs[6]=0x11.
// - Without AUTOINC_EN, same read frame -> MISO byte 2 = 0x00.
// - rst pulsed mid-frame with csn held low -> all outputs return to reset values.
// - After that reset, remaining SCLK edges are ignored until csn goes high then low.
// - SCLK at clk200/8 and at clk200/64 with random async phase -> every case above passes at both rates.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave register bank, oversampled in the clk200 domain.
// Optional build macro: SPI_REGFILE_AUTOINC_EN (address auto-increment for burst access).
`timescale 1ns/1ps

module spi_slave_regfile #(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [7:0]  ID_BYTE  = 8'hA5,
  parameter logic [7:0]  REG_RST  = 8'h00
) (
  input  logic                  clk200,
  input  logic                  rst,
  input  logic                  sclk_i,
  input  logic                  csn_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_stb_o,
  output logic [6:0]            wr_addr_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  // [0],[1] synchronise, [2] holds the previous synced value for edge detection
  logic [2:0] sclk_s;
  logic [2:0] csn_s;
  logic [2:0] mosi_s;

  logic       sclk_rise;
  logic       sclk_fall;
  logic       csn_rise;
  logic       csn_fall;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out;
  logic [7:0] byte_in;
  logic       rw;
  logic [6:0] addr;
  logic       addr_ok;
  logic       load_rd;
  logic       armed;
  logic [7:0] rd_byte;
  logic [7:0] regs [NUM_REGS];

  // csn chain resets low so a frame already in progress at reset release never
  // produces a fall edge until a genuine high level has been observed.
  always_ff @(posedge clk200) begin
    if (rst) begin
      sclk_s <= '0;
      csn_s  <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk_i};
      csn_s  <= {csn_s[1:0], csn_i};
      mosi_s <= {mosi_s[1:0], mosi_i};
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign csn_rise  = csn_s[1] & ~csn_s[2];
  assign csn_fall  = ~csn_s[1] & csn_s[2];

  assign byte_in = {shift_in, mosi_s[1]};
  assign addr_ok = {1'b0, addr} < NUM_REGS_W;

  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr == 7'(i)) rd_byte = regs[i];
    end
  end

  always_ff @(posedge clk200) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      load_rd   <= 1'b0;
      armed     <= 1'b0;
      miso_o    <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      busy_o    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= REG_RST;
    end else begin
      wr_stb_o <= 1'b0;
      load_rd  <= 1'b0;
      if (csn_s[1]) armed <= 1'b1;
      busy_o <= armed & ~csn_s[1];
      if (load_rd) shift_out <= rd_byte;

      case (state)
        IDLE: begin
          miso_o  <= 1'b0;
          bit_cnt <= '0;
          if (csn_fall) begin
            state     <= CMD;
            shift_out <= {ID_BYTE[6:0], 1'b0};
            miso_o    <= ID_BYTE[7];
          end
        end
        CMD, DATA: begin
          if (sclk_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= byte_in[6:0];
            if (bit_cnt == 3'd7) begin
              if (state == CMD) begin
                rw      <= byte_in[7];
                addr    <= byte_in[6:0];
                load_rd <= byte_in[7];
                state   <= DATA;
              end else begin
                if (!rw && addr_ok) begin
                  for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (addr == 7'(i)) regs[i] <= byte_in;
                  end
                  wr_stb_o  <= 1'b1;
                  wr_addr_o <= addr;
                end
`ifdef SPI_REGFILE_AUTOINC_EN
                addr    <= addr + 7'd1;
                load_rd <= rw;
`else
                state <= IGNORE;
`endif
              end
            end
          end
          // Each fall presents the bit at the top of the remaining byte; the fall
          // ending a byte therefore presents the MSB of the freshly loaded one.
          if (sclk_fall) begin
            miso_o    <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
          end
        end
        IGNORE: begin
          miso_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Placed last so a byte completing in the same cycle still commits above.
      if (csn_rise) begin
        state   <= IDLE;
        miso_o  <= 1'b0;
        bit_cnt <= '0;
        load_rd <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_o
    assign regs_o[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: register writes/reads over SPI at two bus rates.
`timescale 1ns/1ps

module tb_spi_slave_regfile;

`ifdef SPI_REGFILE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk200 = 1'b0;
  logic        rst    = 1'b1;
  logic        sclk   = 1'b0;
  logic        csn    = 1'b1;
  logic        mosi   = 1'b0;
  logic        miso;
  logic [63:0] regs;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic        busy;

  spi_slave_regfile #(
    .NUM_REGS (8),
    .ID_BYTE  (8'hA5),
    .REG_RST  (8'h00)
  ) dut (
    .clk200    (clk200),
    .rst       (rst),
    .sclk_i    (sclk),
    .csn_i     (csn),
    .mosi_i    (mosi),
    .miso_o    (miso),
    .regs_o    (regs),
    .wr_stb_o  (wr_stb),
    .wr_addr_o (wr_addr),
    .busy_o    (busy)
  );

  always #2.5 clk200 = ~clk200;

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          stb_cnt   = 0;
  logic [6:0]  stb_addr  = '0;
  int          glitches  = 0;
  logic [63:0] regs_prev;
  real         half      = 20.0;

  always @(negedge clk200) begin
    if (wr_stb) begin
      stb_cnt++;
      stb_addr = wr_addr;
    end
    if (!rst && (regs !== regs_prev) && !wr_stb) glitches++;
    regs_prev = regs;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (half=%0.0fns): got %h expected %h", tag, half, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk200);
  endtask

  // Random sub-cycle phase keeps bus edges asynchronous to clk200.
  task automatic cs_low();
    @(posedge clk200);
    #(0.3 + real'($urandom_range(0, 4400)) / 1000.0);
    csn = 1'b0;
  endtask

  task automatic shift(input int nbits, input logic [31:0] tx, input bit early_cs,
                       output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[31-i];
      #(half);
      rx[31-i] = miso;
      sclk = 1'b1;
      if (early_cs && i == nbits - 1) csn = 1'b1;
      #(half);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    #(half);
    csn = 1'b1;
    wait_clk(12);
  endtask

  task automatic xfer(input int nbits, input logic [31:0] tx, input bit early_cs,
                      output logic [31:0] rx);
    cs_low();
    shift(nbits, tx, early_cs, rx);
    cs_high();
  endtask

  task automatic run_pass();
    logic [63:0] exp;
    logic [31:0] rx;
    int          c0;

    rst = 1'b1;
    wait_clk(4);
    #1 rst = 1'b0;
    @(negedge clk200);
    exp = '0;
    check_eq("rst_regs",    regs,          exp);
    check_eq("rst_miso",    64'(miso),     64'd0);
    check_eq("rst_busy",    64'(busy),     64'd0);
    check_eq("rst_wr_stb",  64'(wr_stb),   64'd0);
    check_eq("rst_wr_addr", 64'(wr_addr),  64'd0);
    wait_clk(8);

    c0 = stb_cnt;
    xfer(16, 32'h035A_0000, 1'b0, rx);
    exp[31:24] = 8'h5A;
    check_eq("wr3_regs",   regs,                exp);
    check_eq("wr3_id",     64'(rx[31:24]),      64'hA5);
    check_eq("wr3_stb",    64'(stb_cnt - c0),   64'd1);
    check_eq("wr3_addr",   64'(stb_addr),       64'd3);

    c0 = stb_cnt;
    xfer(16, 32'h8300_0000, 1'b0, rx);
    check_eq("rd3_id",     64'(rx[31:24]),      64'hA5);
    check_eq("rd3_data",   64'(rx[23:16]),      64'h5A);
    check_eq("rd3_stb",    64'(stb_cnt - c0),   64'd0);
    check_eq("rd3_regs",   regs,                exp);

    c0 = stb_cnt;
    xfer(16, 32'h0AFF_0000, 1'b0, rx);
    check_eq("wr10_stb",   64'(stb_cnt - c0),   64'd0);
    check_eq("wr10_regs",  regs,                exp);

    xfer(16, 32'h8A00_0000, 1'b0, rx);
    check_eq("rd10_data",  64'(rx[23:16]),      64'h00);

    c0 = stb_cnt;
    xfer(12, 32'h02C3_0000, 1'b0, rx);
    check_eq("abort_regs", regs,                exp);
    check_eq("abort_stb",  64'(stb_cnt - c0),   64'd0);
    check_eq("abort_busy", 64'(busy),           64'd0);

    c0 = stb_cnt;
    xfer(16, 32'h02C3_0000, 1'b0, rx);
    exp[23:16] = 8'hC3;
    check_eq("wr2_regs",   regs,                exp);
    check_eq("wr2_stb",    64'(stb_cnt - c0),   64'd1);
    check_eq("wr2_addr",   64'(stb_addr),       64'd2);

    c0 = stb_cnt;
    xfer(16, 32'h013C_0000, 1'b1, rx);
    exp[15:8] = 8'h3C;
    check_eq("early_cs_regs", regs,              exp);
    check_eq("early_cs_stb",  64'(stb_cnt - c0), 64'd1);

    c0 = stb_cnt;
    xfer(32, 32'h0611_2233, 1'b0, rx);
    exp[55:48] = 8'h11;
    exp[63:56] = AUTOINC ? 8'h22 : 8'h00;
    check_eq("burst_wr_regs", regs,              exp);
    check_eq("burst_wr_stb",  64'(stb_cnt - c0), AUTOINC ? 64'd2 : 64'd1);

    xfer(24, 32'h8600_0000, 1'b0, rx);
    check_eq("burst_rd_b1", 64'(rx[23:16]),     64'h11);
    check_eq("burst_rd_b2", 64'(rx[15:8]),      AUTOINC ? 64'h22 : 64'h00);

    // Reset while a frame is running with csn held low.
    cs_low();
    shift(5, 32'h8400_0000, 1'b0, rx);
    wait_clk(4);
    @(negedge clk200);
    check_eq("midrst_busy_before", 64'(busy), 64'd1);
    @(posedge clk200);
    #1 rst = 1'b1;
    wait_clk(3);
    #1 rst = 1'b0;
    @(negedge clk200);
    exp = '0;
    check_eq("midrst_regs",    regs,         exp);
    check_eq("midrst_miso",    64'(miso),    64'd0);
    check_eq("midrst_wr_stb",  64'(wr_stb),  64'd0);
    check_eq("midrst_wr_addr", 64'(wr_addr), 64'd0);
    check_eq("midrst_busy",    64'(busy),    64'd0);

    c0 = stb_cnt;
    shift(16, 32'h0177_0000, 1'b0, rx);
    wait_clk(12);
    @(negedge clk200);
    check_eq("postrst_regs", regs,              exp);
    check_eq("postrst_stb",  64'(stb_cnt - c0), 64'd0);
    check_eq("postrst_busy", 64'(busy),         64'd0);
    check_eq("postrst_miso", 64'(rx),           64'd0);
    cs_high();

    xfer(16, 32'h8100_0000, 1'b0, rx);
    check_eq("postrst_rd_id",   64'(rx[31:24]), 64'hA5);
    check_eq("postrst_rd_data", 64'(rx[23:16]), 64'h00);

    xfer(16, 32'h0177_0000, 1'b0, rx);
    exp[15:8] = 8'h77;
    check_eq("postrst_wr_regs", regs,            exp);
    check_eq("postrst_wr_addr", 64'(stb_addr),   64'd1);

    check_eq("regs_stable", 64'(glitches), 64'd0);
  endtask

  initial begin
    half = 20.0;
    run_pass();
    half = 160.0;
    run_pass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
